tl_c_msg_monitor: RTL and testbench
===================================

# tl_c_msg_monitor

Passive consumer of the hart-0 data-cache TileLink channel C (ProbeAck/ProbeAckData/Release/ReleaseData) trace signals. Samples every handshaked beat, assembles multi-beat messages into one record with a data checksum, checks header consistency and legality, and queues records in a small FIFO for the trace/debug aggregator. Never drives the channel; exerts no backpressure on the cache.

## Interface
- `FIFO_DEPTH`, 4: record FIFO entries, power of two, ≥2.
- `MAX_SIZE`, 6: largest legal `lgSize` (64 B = 16 beats of 32 bits).
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `c_valid`, `c_ready`  in  1 each  channel handshake; a beat fires when both are 1.
- `c_opcode`  in  3  TileLink C opcode.
- `c_param`  in  3  shrink/report param.
- `c_size`  in  4  lgSize.
- `c_source`  in  1  source ID.
- `c_address`  in  32  byte address.
- `c_data`  in  32  beat data.
- `c_corrupt`  in  1  beat corrupt flag.
- `rec_valid`  out  1  FIFO head valid.
- `rec_ready`  in  1  consumer pops head when `rec_valid && rec_ready`.
- `rec_opcode`, `rec_param`  out  3 each; `rec_size` out 4; `rec_source` out 1; `rec_address` out 32  first-beat header.
- `rec_beats`  out  5  beats observed (1..16).
- `rec_csum`  out  32  XOR of all beat data (0 for dataless opcodes).
- `rec_corrupt`  out  1  OR of beat corrupt flags.
- `rec_err`  out  1  any protocol error in the message.
- `drop_count`  out  16  records lost to a full FIFO, saturating.
- `err_count`  out  16  records with `rec_err`, saturating; counts dropped ones too.

## Operation
- Valid opcodes: 4 ProbeAck, 5 ProbeAckData, 6 Release, 7 ReleaseData; `opcode[0]` = has data.
- Expected beats: 1 if dataless or `size ≤ 2`, else `2^(size-2)`.
- FSM `IDLE`/`BURST`. IDLE + fire: latch header, init csum (data if has-data, else 0), corrupt, err; if expected beats = 1 complete immediately, else go BURST with `beat_cnt = 1`.
- BURST + fire: XOR data into csum, OR corrupt, compare header fields with latched copy, increment `beat_cnt`; on `beat_cnt + 1 == expected` complete, return IDLE.
- Errors (set `rec_err`): opcode 0–3; `size > MAX_SIZE`; address not aligned to `2^size`; `param > 5`; any header field changing mid-burst. Erroneous `size` is clamped to `MAX_SIZE` for beat counting.
- Completion: if FIFO not full (registered status at start of cycle), push record; otherwise drop and increment `drop_count`. A pop in the same cycle does not rescue a push into a full FIFO.
- `err_count` increments on every completed erroneous record.

## Timing
- Reset: FSM IDLE, `beat_cnt`/csum/header regs 0, FIFO empty, `rec_valid` 0, all `rec_*` 0, both counters 0. Reset mid-burst discards the partial message.
- Record visible on `rec_valid` the cycle after its last beat fires (1-cycle latency); `rec_*` come straight from the FIFO head register.
- Back-to-back messages with no idle cycle are supported; the first beat of the next message may fire the cycle after the previous completion.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.
- `rec_*` stable while `rec_valid && !rec_ready`.
- Counters saturate at 0xFFFF and never wrap.

## Structure
- Package `tl_c_pkg`: opcode enum, record struct (header, beats, csum, corrupt, err), `MAX_SIZE` default, `exp_beats(opcode, size)` function.
- Sub-module `tl_c_rec_fifo`: synchronous FIFO of records, depth `FIFO_DEPTH`, registered full/empty, async active-low reset.

## Test plan
- ReleaseData, size 6, addr 0x8000_0040, data 1..16 -> one record after 16 beats, `rec_beats` 16, `rec_csum` 0x10, `rec_err` 0.
- ProbeAck, size 6, param 3 -> record after 1 beat, `rec_beats` 1, `rec_csum` 0, next cycle `rec_valid` 1.
- ProbeAckData, size 4, `c_param` changes on beat 3 -> `rec_beats` 4, `rec_err` 1, `err_count` 1.
- Release, size 3, addr 0x8000_0004 (misaligned) -> `rec_err` 1; opcode 2 -> `rec_err` 1.
- `rec_ready` 0, five single-beat ProbeAcks with depth 4 -> four queued, `drop_count` 1; pop then resume in order.
- Assert `reset_n` low after beat 2 of a 4-beat ReleaseData -> FIFO empty, counters 0; next message records correctly.

Source files
------------

// File: rtl/tl_c_pkg.sv
// rtl/tl_c_pkg.sv - shared types and helpers for the TileLink channel C monitor
package tl_c_pkg;

  localparam int MAX_SIZE_DEF = 6;

  typedef enum logic [2:0] {
    OP_PROBE_ACK      = 3'd4,
    OP_PROBE_ACK_DATA = 3'd5,
    OP_RELEASE        = 3'd6,
    OP_RELEASE_DATA   = 3'd7
  } tlCOpcode_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic        source;
    logic [31:0] address;
  } tlCHdr_t;

  typedef struct packed {
    tlCHdr_t     hdr;
    logic [4:0]  beats;
    logic [31:0] csum;
    logic        corrupt;
    logic        err;
  } tlCRec_t;

  // Beats a message occupies on the 32-bit channel; size must already be clamped.
  function automatic logic [4:0] exp_beats(input logic [2:0] opcode, input logic [3:0] size);
    if (!opcode[0] || size <= 4'd2) begin
      return 5'd1;
    end
    return 5'd1 << (size - 4'd2);
  endfunction

endpackage

// File: rtl/tl_c_rec_fifo.sv
// rtl/tl_c_rec_fifo.sv - record FIFO with registered full/empty status
module tl_c_rec_fifo
  import tl_c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    pushValid,
  input  tlCRec_t pushRec,
  input  logic    popReady,
  output logic    headValid,
  output tlCRec_t headRec,
  output logic    full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tlCRec_t        mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW:0]    count;
  logic [AW:0]    countNext;
  logic           empty;
  logic           doPush;
  logic           doPop;

  // A push is refused when full even if the head pops this cycle.
  assign doPush    = pushValid && !full;
  assign doPop     = !empty && popReady;
  assign headValid = !empty;
  assign headRec   = mem[rdPtr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      full  <= (countNext == DEPTH[AW:0]);
      empty <= (countNext == '0);
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (doPush) begin
      mem[wrPtr] <= pushRec;
    end
  end

endmodule

// File: rtl/tl_c_msg_monitor.sv
// rtl/tl_c_msg_monitor.sv - passive channel C message assembler and checker
module tl_c_msg_monitor
  import tl_c_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SIZE   = MAX_SIZE_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        c_valid,
  input  logic        c_ready,
  input  logic [2:0]  c_opcode,
  input  logic [2:0]  c_param,
  input  logic [3:0]  c_size,
  input  logic        c_source,
  input  logic [31:0] c_address,
  input  logic [31:0] c_data,
  input  logic        c_corrupt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_opcode,
  output logic [2:0]  rec_param,
  output logic [3:0]  rec_size,
  output logic        rec_source,
  output logic [31:0] rec_address,
  output logic [4:0]  rec_beats,
  output logic [31:0] rec_csum,
  output logic        rec_corrupt,
  output logic        rec_err,
  output logic [15:0] drop_count,
  output logic [15:0] err_count
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e      state;
  state_e      stateNext;

  tlCHdr_t     curHdr;
  tlCHdr_t     hdrReg;
  logic [31:0] csumReg;
  logic        corruptReg;
  logic        errReg;
  logic [4:0]  beatCnt;
  logic [4:0]  expReg;

  logic        fire;
  logic [3:0]  sizeClamped;
  logic [4:0]  beatsNow;
  logic [31:0] alignMask;
  logic [31:0] dataNow;
  logic        hdrErr;
  logic        hdrMismatch;

  logic        done;
  logic        latchFirst;
  logic        accumBeat;
  tlCRec_t     doneRec;

  logic        fifoFull;
  tlCRec_t     headRec;

  assign fire        = c_valid && c_ready;
  assign curHdr      = {c_opcode, c_param, c_size, c_source, c_address};
  assign sizeClamped = (c_size > MAX_SIZE[3:0]) ? MAX_SIZE[3:0] : c_size;
  assign beatsNow    = exp_beats(c_opcode, sizeClamped);
  assign alignMask   = (32'd1 << c_size) - 32'd1;
  assign dataNow     = c_opcode[0] ? c_data : 32'd0;
  assign hdrErr      = (c_opcode < OP_PROBE_ACK) || (c_size > MAX_SIZE[3:0]) ||
                       ((c_address & alignMask) != 32'd0) || (c_param > 3'd5);
  assign hdrMismatch = (curHdr != hdrReg);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and the completed record, built from latched state plus the current beat.
  always_comb begin
    stateNext  = state;
    done       = 1'b0;
    latchFirst = 1'b0;
    accumBeat  = 1'b0;
    doneRec    = '0;
    case (state)
      IDLE: begin
        if (fire) begin
          latchFirst = 1'b1;
          if (beatsNow == 5'd1) begin
            done            = 1'b1;
            doneRec.hdr     = curHdr;
            doneRec.beats   = 5'd1;
            doneRec.csum    = dataNow;
            doneRec.corrupt = c_corrupt;
            doneRec.err     = hdrErr;
          end else begin
            stateNext = BURST;
          end
        end
      end
      BURST: begin
        if (fire) begin
          accumBeat = 1'b1;
          if (beatCnt + 5'd1 == expReg) begin
            done            = 1'b1;
            stateNext       = IDLE;
            doneRec.hdr     = hdrReg;
            doneRec.beats   = beatCnt + 5'd1;
            doneRec.csum    = csumReg ^ c_data;
            doneRec.corrupt = corruptReg | c_corrupt;
            doneRec.err     = errReg | hdrMismatch;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Header latch and running checksum/flags for the message in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdrReg     <= '0;
      csumReg    <= '0;
      corruptReg <= 1'b0;
      errReg     <= 1'b0;
      beatCnt    <= '0;
      expReg     <= '0;
    end else if (latchFirst) begin
      hdrReg     <= curHdr;
      csumReg    <= dataNow;
      corruptReg <= c_corrupt;
      errReg     <= hdrErr;
      beatCnt    <= 5'd1;
      expReg     <= beatsNow;
    end else if (accumBeat) begin
      csumReg    <= csumReg ^ c_data;
      corruptReg <= corruptReg | c_corrupt;
      errReg     <= errReg | hdrMismatch;
      beatCnt    <= beatCnt + 5'd1;
    end
  end

  // Saturating drop and error counters; errors count whether or not the record is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (done && fifoFull && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      if (done && doneRec.err && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  tl_c_rec_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .pushValid(done),
    .pushRec  (doneRec),
    .popReady (rec_ready),
    .headValid(rec_valid),
    .headRec  (headRec),
    .full     (fifoFull)
  );

  assign rec_opcode  = headRec.hdr.opcode;
  assign rec_param   = headRec.hdr.param;
  assign rec_size    = headRec.hdr.size;
  assign rec_source  = headRec.hdr.source;
  assign rec_address = headRec.hdr.address;
  assign rec_beats   = headRec.beats;
  assign rec_csum    = headRec.csum;
  assign rec_corrupt = headRec.corrupt;
  assign rec_err     = headRec.err;

endmodule

// File: tb/tb_tl_c_msg_monitor.sv
// tb/tb_tl_c_msg_monitor.sv - directed self-checking bench for tl_c_msg_monitor
module tb_tl_c_msg_monitor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        c_valid, c_ready;
  logic [2:0]  c_opcode, c_param;
  logic [3:0]  c_size;
  logic        c_source;
  logic [31:0] c_address, c_data;
  logic        c_corrupt;
  logic        rec_valid, rec_ready;
  logic [2:0]  rec_opcode, rec_param;
  logic [3:0]  rec_size;
  logic        rec_source;
  logic [31:0] rec_address;
  logic [4:0]  rec_beats;
  logic [31:0] rec_csum;
  logic        rec_corrupt, rec_err;
  logic [15:0] drop_count, err_count;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  tl_c_msg_monitor dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .c_opcode   (c_opcode),
    .c_param    (c_param),
    .c_size     (c_size),
    .c_source   (c_source),
    .c_address  (c_address),
    .c_data     (c_data),
    .c_corrupt  (c_corrupt),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_opcode (rec_opcode),
    .rec_param  (rec_param),
    .rec_size   (rec_size),
    .rec_source (rec_source),
    .rec_address(rec_address),
    .rec_beats  (rec_beats),
    .rec_csum   (rec_csum),
    .rec_corrupt(rec_corrupt),
    .rec_err    (rec_err),
    .drop_count (drop_count),
    .err_count  (err_count)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBeat(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [31:0] dat, input logic corr);
    c_valid   = 1'b1;
    c_opcode  = op;
    c_param   = prm;
    c_size    = sz;
    c_source  = 1'b0;
    c_address = addr;
    c_data    = dat;
    c_corrupt = corr;
    @(posedge clock);
    #1;
    c_valid   = 1'b0;
    c_corrupt = 1'b0;
  endtask

  task automatic popOne();
    rec_ready = 1'b1;
    @(posedge clock);
    #1;
    rec_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    c_valid = 1'b0; c_ready = 1'b1; rec_ready = 1'b0;
    c_opcode = '0; c_param = '0; c_size = '0; c_source = 1'b0;
    c_address = '0; c_data = '0; c_corrupt = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkVal("rst_valid", rec_valid, 0);
    checkVal("rst_csum", rec_csum, 0);
    checkVal("rst_addr", rec_address, 0);
    checkVal("rst_drop", drop_count, 0);
    checkVal("rst_err", err_count, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ReleaseData, 16 beats, data 1..16
    for (int i = 1; i <= 16; i++) begin
      sendBeat(3'd7, 3'd0, 4'd6, 32'h8000_0040, i, 1'b0);
      if (i == 15) checkVal("t1_not_early", rec_valid, 0);
    end
    checkVal("t1_valid", rec_valid, 1);
    checkVal("t1_opcode", rec_opcode, 7);
    checkVal("t1_size", rec_size, 6);
    checkVal("t1_addr", rec_address, 32'h8000_0040);
    checkVal("t1_beats", rec_beats, 16);
    checkVal("t1_csum", rec_csum, 32'h10);
    checkVal("t1_err", rec_err, 0);
    popOne();
    checkVal("t1_popped", rec_valid, 0);

    // valid without ready must not be sampled
    c_valid = 1'b1; c_ready = 1'b0; c_opcode = 3'd4; c_size = 4'd0; c_address = '0;
    @(posedge clock);
    #1;
    c_valid = 1'b0; c_ready = 1'b1;
    checkVal("noready_nofire", rec_valid, 0);

    // ProbeAck single beat, data ignored
    sendBeat(3'd4, 3'd3, 4'd6, 32'h8000_0040, 32'hDEAD_BEEF, 1'b0);
    checkVal("t2_valid", rec_valid, 1);
    checkVal("t2_param", rec_param, 3);
    checkVal("t2_beats", rec_beats, 1);
    checkVal("t2_csum", rec_csum, 0);
    checkVal("t2_err", rec_err, 0);
    popOne();

    // ProbeAckData, 4 beats, param changes on beat 3, corrupt on beat 2
    for (int i = 1; i <= 4; i++) begin
      sendBeat(3'd5, (i == 3) ? 3'd1 : 3'd0, 4'd4, 32'h8000_0000, 32'h11 * i, (i == 2));
    end
    checkVal("t3_beats", rec_beats, 4);
    checkVal("t3_csum", rec_csum, 32'h44);
    checkVal("t3_corrupt", rec_corrupt, 1);
    checkVal("t3_err", rec_err, 1);
    checkVal("t3_errcnt", err_count, 1);
    popOne();

    // misaligned Release, then illegal opcode 2
    sendBeat(3'd6, 3'd0, 4'd3, 32'h8000_0004, 32'h0, 1'b0);
    checkVal("t4_misalign_err", rec_err, 1);
    checkVal("t4_misalign_beats", rec_beats, 1);
    checkVal("t4_errcnt1", err_count, 2);
    popOne();
    sendBeat(3'd2, 3'd0, 4'd0, 32'h8000_0000, 32'h0, 1'b0);
    checkVal("t4_opcode_err", rec_err, 1);
    checkVal("t4_errcnt2", err_count, 3);
    popOne();
    checkVal("t4_empty", rec_valid, 0);

    // five back-to-back ProbeAcks into a depth-4 FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      sendBeat(3'd4, i[2:0], 4'd2, 32'h100 * i, 32'h0, 1'b0);
    end
    checkVal("t5_drop", drop_count, 1);
    checkVal("t5_valid", rec_valid, 1);
    @(posedge clock);
    #1;
    checkVal("t5_stable", rec_param, 0);
    for (int i = 0; i < 4; i++) begin
      checkVal("t5_order_param", rec_param, i);
      checkVal("t5_order_addr", rec_address, 32'h100 * i);
      popOne();
    end
    checkVal("t5_drained", rec_valid, 0);

    // reset in the middle of a 4-beat ReleaseData with a record queued
    sendBeat(3'd4, 3'd0, 4'd0, 32'h0, 32'h0, 1'b0);
    sendBeat(3'd7, 3'd0, 4'd4, 32'h8000_0010, 32'h1, 1'b0);
    sendBeat(3'd7, 3'd0, 4'd4, 32'h8000_0010, 32'h2, 1'b0);
    reset_n = 1'b0;
    #3;
    checkVal("t6_rst_valid", rec_valid, 0);
    checkVal("t6_rst_drop", drop_count, 0);
    checkVal("t6_rst_err", err_count, 0);
    checkVal("t6_rst_addr", rec_address, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    sendBeat(3'd7, 3'd0, 4'd3, 32'h8000_0008, 32'hA5, 1'b0);
    sendBeat(3'd7, 3'd0, 4'd3, 32'h8000_0008, 32'h5A, 1'b0);
    sendBeat(3'd4, 3'd1, 4'd6, 32'h8000_0040, 32'h0, 1'b0);
    checkVal("t6_opcode", rec_opcode, 7);
    checkVal("t6_beats", rec_beats, 2);
    checkVal("t6_csum", rec_csum, 32'hFF);
    checkVal("t6_err", rec_err, 0);
    popOne();
    checkVal("t6_second_op", rec_opcode, 4);
    checkVal("t6_second_param", rec_param, 1);
    popOne();
    checkVal("t6_empty", rec_valid, 0);
    checkVal("t6_errcnt", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
